// File: rtl/comb_pkg.sv
// Shared types and default sizes for the combination-stage row scheduler.
// Also provides the index-width helper used by the scheduler and its counter.
package comb_pkg;

    localparam int unsigned DEF_FEATURE_ROWS   = 6;
    localparam int unsigned DEF_WEIGHT_COLS    = 3;
    localparam int unsigned DEF_DOT_PROD_WIDTH = 16;

    typedef logic [DEF_DOT_PROD_WIDTH-1:0] dot_t;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        WRITE,
        FIN
    } state_e;

    // Index width for n entries; a single-entry range still needs one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/comb_index_counter.sv
// Nested row/column index counter. The column wraps to 0 on next_row, and
// neither index ever moves past its terminal value.
module comb_index_counter
    import comb_pkg::*;
#(
    parameter int unsigned ROWS  = DEF_FEATURE_ROWS,
    parameter int unsigned COLS  = DEF_WEIGHT_COLS,
    parameter int unsigned ROW_W = idx_width(ROWS),
    parameter int unsigned COL_W = idx_width(COLS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             inc_col,
    input  logic             next_row,
    output logic [ROW_W-1:0] row,
    output logic [COL_W-1:0] col,
    output logic             last_col,
    output logic             last_row
);

    logic [ROW_W-1:0] row_q, row_d;
    logic [COL_W-1:0] col_q, col_d;

    assign last_col = (col_q == COL_W'(COLS - 1));
    assign last_row = (row_q == ROW_W'(ROWS - 1));
    assign row      = row_q;
    assign col      = col_q;

    always_comb begin
        row_d = row_q;
        col_d = col_q;
        if (clear) begin
            row_d = '0;
            col_d = '0;
        end else if (next_row) begin
            col_d = '0;
            if (!last_row) begin
                row_d = row_q + ROW_W'(1);
            end
        end else if (inc_col && !last_col) begin
            col_d = col_q + COL_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_q <= '0;
            col_q <= '0;
        end else begin
            row_q <= row_d;
            col_q <= col_d;
        end
    end

endmodule

// File: rtl/comb_row_scheduler.sv
// Walks every (feature row, weight column) pair, issues one dot-product request
// each, gathers a row of results and writes the full row to the result memory.
module comb_row_scheduler
    import comb_pkg::*;
#(
    parameter int unsigned FEATURE_ROWS          = DEF_FEATURE_ROWS,
    parameter int unsigned WEIGHT_COLS           = DEF_WEIGHT_COLS,
    parameter int unsigned DOT_PROD_WIDTH        = DEF_DOT_PROD_WIDTH,
    parameter int unsigned COUNTER_FEATURE_WIDTH = idx_width(FEATURE_ROWS),
    parameter int unsigned COUNTER_WEIGHT_WIDTH  = idx_width(WEIGHT_COLS)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start,
    input  logic                             abort,
    output logic [COUNTER_FEATURE_WIDTH-1:0] feature_row,
    output logic [COUNTER_WEIGHT_WIDTH-1:0]  weight_col,
    output logic                             dp_req,
    input  logic                             dp_valid,
    input  logic [DOT_PROD_WIDTH-1:0]        dp_result,
    output logic                             wr_en,
    output logic [COUNTER_FEATURE_WIDTH-1:0] write_row,
    output logic [DOT_PROD_WIDTH-1:0]        fm_wm_row_out [0:WEIGHT_COLS-1],
    output logic                             busy,
    output logic                             done
);

    state_e state_q, state_d;

    logic cnt_clear;
    logic inc_col;
    logic next_row;
    logic last_col;
    logic last_row;
    logic buf_we;

    logic [COUNTER_FEATURE_WIDTH-1:0] row;
    logic [COUNTER_WEIGHT_WIDTH-1:0]  col;
    logic [DOT_PROD_WIDTH-1:0]        rowbuf_q [0:WEIGHT_COLS-1];

    comb_index_counter #(
        .ROWS  (FEATURE_ROWS),
        .COLS  (WEIGHT_COLS),
        .ROW_W (COUNTER_FEATURE_WIDTH),
        .COL_W (COUNTER_WEIGHT_WIDTH)
    ) u_index (
        .clk      (clk),
        .rst      (rst),
        .clear    (cnt_clear),
        .inc_col  (inc_col),
        .next_row (next_row),
        .row      (row),
        .col      (col),
        .last_col (last_col),
        .last_row (last_row)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // abort overrides every transition, including start and a same-cycle dp_valid.
    always_comb begin
        state_d   = state_q;
        cnt_clear = 1'b0;
        inc_col   = 1'b0;
        next_row  = 1'b0;
        buf_we    = 1'b0;
        if (abort) begin
            state_d   = IDLE;
            cnt_clear = 1'b1;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        state_d   = REQ;
                        cnt_clear = 1'b1;
                    end
                end
                REQ: begin
                    state_d = WAIT;
                end
                WAIT: begin
                    if (dp_valid) begin
                        buf_we = 1'b1;
                        if (last_col) begin
                            state_d = WRITE;
                        end else begin
                            inc_col = 1'b1;
                            state_d = REQ;
                        end
                    end
                end
                WRITE: begin
                    if (last_row) begin
                        state_d = FIN;
                    end else begin
                        next_row = 1'b1;
                        state_d  = REQ;
                    end
                end
                FIN: begin
                    state_d   = IDLE;
                    cnt_clear = 1'b1;
                end
                default: begin
                    state_d   = IDLE;
                    cnt_clear = 1'b1;
                end
            endcase
        end
    end

    always_comb begin
        dp_req = 1'b0;
        wr_en  = 1'b0;
        done   = 1'b0;
        busy   = 1'b1;
        unique case (state_q)
            IDLE:    busy   = 1'b0;
            REQ:     dp_req = 1'b1;
            WRITE:   wr_en  = 1'b1;
            FIN:     done   = 1'b1;
            default: ;
        endcase
    end

    // Per-entry compare keeps the write in range for non-power-of-two widths.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(WEIGHT_COLS); i++) begin
                rowbuf_q[i] <= '0;
            end
        end else if (buf_we) begin
            for (int i = 0; i < int'(WEIGHT_COLS); i++) begin
                if (col == COUNTER_WEIGHT_WIDTH'(i)) begin
                    rowbuf_q[i] <= dp_result;
                end
            end
        end
    end

    assign feature_row   = row;
    assign weight_col    = col;
    assign write_row     = row;
    assign fm_wm_row_out = rowbuf_q;

endmodule

// File: tb/tb_comb_row_scheduler.sv
// Directed bench for comb_row_scheduler: a latency-configurable dot-product
// model, a queue of expected row writes, and a second 5x1 instance.
module tb_comb_row_scheduler;
    import comb_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Default 6x3 instance
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [2:0]  feature_row;
    logic [1:0]  weight_col;
    logic        dp_req;
    logic        dp_valid;
    dot_t        dp_result;
    logic        wr_en;
    logic [2:0]  write_row;
    dot_t        row_out [0:2];
    logic        busy;
    logic        done;

    // 5x1 instance
    logic        start2 = 1'b0;
    logic        abort2 = 1'b0;
    logic [2:0]  feature_row2;
    logic [0:0]  weight_col2;
    logic        dp_req2;
    logic        dp_valid2 = 1'b0;
    dot_t        dp_result2 = '0;
    logic        wr_en2;
    logic [2:0]  write_row2;
    dot_t        row_out2 [0:0];
    logic        busy2;
    logic        done2;

    comb_row_scheduler dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .abort         (abort),
        .feature_row   (feature_row),
        .weight_col    (weight_col),
        .dp_req        (dp_req),
        .dp_valid      (dp_valid),
        .dp_result     (dp_result),
        .wr_en         (wr_en),
        .write_row     (write_row),
        .fm_wm_row_out (row_out),
        .busy          (busy),
        .done          (done)
    );

    comb_row_scheduler #(
        .FEATURE_ROWS (5),
        .WEIGHT_COLS  (1)
    ) dut2 (
        .clk           (clk),
        .rst           (rst),
        .start         (start2),
        .abort         (abort2),
        .feature_row   (feature_row2),
        .weight_col    (weight_col2),
        .dp_req        (dp_req2),
        .dp_valid      (dp_valid2),
        .dp_result     (dp_result2),
        .wr_en         (wr_en2),
        .write_row     (write_row2),
        .fm_wm_row_out (row_out2),
        .busy          (busy2),
        .done          (done2)
    );

    // Dot-product model: answers each request L cycles later with row*16+col.
    int   lat_fixed = 2;
    bit   lat_rand  = 1'b0;
    int   pend      = 0;
    dot_t pend_res  = '0;
    logic mdl_valid = 1'b0;
    dot_t mdl_res   = '0;
    logic spur_valid = 1'b0;
    dot_t spur_res   = 16'hdead;

    assign dp_valid  = mdl_valid | spur_valid;
    assign dp_result = mdl_valid ? mdl_res : spur_res;

    always @(posedge clk) begin
        #1;
        mdl_valid = 1'b0;
        if (rst) begin
            pend = 0;
        end else begin
            if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    mdl_valid = 1'b1;
                    mdl_res   = pend_res;
                end
            end
            if (dp_req === 1'b1) begin
                pend     = lat_rand ? int'($urandom_range(5, 1)) : lat_fixed;
                pend_res = (dot_t'(feature_row) << 4) | dot_t'(weight_col);
            end
        end
    end

    // Latency-1 responder for the 5x1 instance.
    always @(posedge clk) begin
        dp_valid2  <= dp_req2;
        dp_result2 <= dot_t'(feature_row2) << 4;
    end

    int n_tests = 0;
    int n_fail  = 0;
    int cyc, wr_cnt, req_cnt, done_cnt, first_req, done_cyc;
    int wr2_cnt, done2_cnt, max_row2, col2_nz;
    logic [63:0] exp_q [$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] exp_row(input int r);
        return {13'd0, 3'(r), 16'(r * 16), 16'(r * 16 + 1), 16'(r * 16 + 2)};
    endfunction

    function automatic logic [63:0] obs_row();
        return {13'd0, write_row, row_out[0], row_out[1], row_out[2]};
    endfunction

    task automatic clear_counts();
        cyc = 0; wr_cnt = 0; req_cnt = 0; done_cnt = 0; first_req = -1; done_cyc = -1;
    endtask

    // Advance one cycle and observe both instances at the falling edge.
    task automatic step();
        @(negedge clk);
        cyc++;
        if (dp_req === 1'b1) begin
            req_cnt++;
            if (first_req < 0) first_req = cyc;
        end
        if (done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (wr_en === 1'b1) begin
            wr_cnt++;
            if (exp_q.size() == 0) check("rows_pending_at_write", 64'(exp_q.size()), 64'd1);
            else check("row_write", obs_row(), exp_q.pop_front());
        end
        if (wr_en2 === 1'b1) wr2_cnt++;
        if (done2 === 1'b1) done2_cnt++;
        if (int'(feature_row2) > max_row2) max_row2 = int'(feature_row2);
        if (weight_col2 !== 1'b0) col2_nz++;
    endtask

    task automatic run_pass(input int lat, input bit rnd, input bit spur, input bit span,
                            input string tag);
        bit spur_chk;
        lat_fixed = lat;
        lat_rand  = rnd;
        clear_counts();
        for (int r = 0; r < 6; r++) exp_q.push_back(exp_row(r));
        start = 1'b1;
        step();
        start = 1'b0;
        spur_chk = 1'b0;
        for (int k = 0; k < 400 && done_cnt == 0; k++) begin
            step();
            start      = 1'b0;
            spur_valid = 1'b0;
            if (spur_chk) begin
                check({tag, "_spurious_valid_ignored"}, 64'(row_out[1]), 64'(3 * 16 + 1));
                spur_chk = 1'b0;
            end
            if (spur && k == 20) start = 1'b1;
            if (spur && dp_req === 1'b1 && req_cnt == 14) begin
                spur_valid = 1'b1;
                spur_chk   = 1'b1;
            end
        end
        start      = 1'b0;
        spur_valid = 1'b0;
        repeat (20) step();
        check({tag, "_wr_count"}, 64'(wr_cnt), 64'd6);
        check({tag, "_req_count"}, 64'(req_cnt), 64'd18);
        check({tag, "_done_count"}, 64'(done_cnt), 64'd1);
        check({tag, "_rows_left"}, 64'(exp_q.size()), 64'd0);
        check({tag, "_idle_after"}, 64'(busy), 64'd0);
        if (span) check({tag, "_pass_cycles"}, 64'(done_cyc - first_req + 1), 64'd61);
        exp_q.delete();
    endtask

    initial begin
        bit found;
        wr2_cnt = 0; done2_cnt = 0; max_row2 = 0; col2_nz = 0;
        clear_counts();
        repeat (2) @(negedge clk);

        // Reset values
        check("rst_state", 64'(dut.state_q), 64'(IDLE));
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_dp_req", 64'(dp_req), 64'd0);
        check("rst_wr_en", 64'(wr_en), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_addr", 64'({feature_row, weight_col, write_row}), 64'd0);
        check("rst_rowbuf", 64'({row_out[0], row_out[1], row_out[2]}), 64'd0);
        rst = 1'b0;
        step();

        run_pass(2, 1'b0, 1'b1, 1'b1, "basic");
        run_pass(0, 1'b1, 1'b0, 1'b0, "randlat");

        // Abort in WAIT of row 2, col 1
        lat_fixed = 2;
        lat_rand  = 1'b0;
        clear_counts();
        exp_q.push_back(exp_row(0));
        exp_q.push_back(exp_row(1));
        start = 1'b1;
        step();
        start = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 200 && !found; k++) begin
            step();
            if (busy && !dp_req && !wr_en && feature_row == 3'd2 && weight_col == 2'd1)
                found = 1'b1;
        end
        check("abort_point_reached", 64'(found), 64'd1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("abort_state", 64'(dut.state_q), 64'(IDLE));
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_addr", 64'({feature_row, weight_col}), 64'd0);
        repeat (30) step();
        check("abort_wr_count", 64'(wr_cnt), 64'd2);
        check("abort_no_done", 64'(done_cnt), 64'd0);
        check("abort_rows_left", 64'(exp_q.size()), 64'd0);
        exp_q.delete();

        run_pass(3, 1'b0, 1'b0, 1'b0, "after_abort");

        // Asynchronous reset mid-pass
        lat_fixed = 2;
        clear_counts();
        exp_q.push_back(exp_row(0));
        exp_q.push_back(exp_row(1));
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (25) step();
        #2 rst = 1'b1;
        #1;
        check("midrst_state", 64'(dut.state_q), 64'(IDLE));
        check("midrst_outputs", 64'({busy, dp_req, wr_en, done}), 64'd0);
        check("midrst_addr", 64'({feature_row, weight_col, write_row}), 64'd0);
        check("midrst_rowbuf", 64'({row_out[0], row_out[1], row_out[2]}), 64'd0);
        repeat (3) step();
        rst = 1'b0;
        repeat (5) step();
        check("midrst_wr_count", 64'(wr_cnt), 64'd2);
        check("midrst_no_done", 64'(done_cnt), 64'd0);
        exp_q.delete();

        // 5x1 instance
        wr2_cnt = 0; done2_cnt = 0; max_row2 = 0; col2_nz = 0;
        start2 = 1'b1;
        step();
        start2 = 1'b0;
        for (int k = 0; k < 100 && done2_cnt == 0; k++) step();
        repeat (5) step();
        check("np2_wr_count", 64'(wr2_cnt), 64'd5);
        check("np2_done_count", 64'(done2_cnt), 64'd1);
        check("np2_max_row", 64'(max_row2), 64'd4);
        check("np2_col_nonzero", 64'(col2_nz), 64'd0);
        check("np2_last_value", 64'(row_out2[0]), 64'(4 * 16));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
